// File: rtl/case_9_mul_rr_arbiter_if.sv
// Requester operand channels and the single result channel of the
// shared-multiplier arbiter; the arbiter connects through the slave modport.
interface case_9_mul_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DIN_W = 10,
  parameter int OUT_W = 10,
  parameter int ID_W  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DIN_W-1:0] req_a;
  logic [NREQ*DIN_W-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [OUT_W-1:0]      res_data;
  logic [ID_W-1:0]       res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/case_9_mul_rr_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NREQ requesters;
// one grant per cycle into a single registered, id-tagged result slot.
module case_9_mul_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DIN_W = 10,
  parameter int OUT_W = 10,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  case_9_mul_rr_arbiter_if.slave bus,
  output logic [CNT_W-1:0]      issue_cnt
);

  logic [ID_W-1:0]    r_ptr;
  logic               r_res_valid;
  logic [OUT_W-1:0]   r_res_data;
  logic [ID_W-1:0]    r_res_id;
  logic [CNT_W-1:0]   r_issue_cnt;

  logic               w_slot;
  logic               w_found;
  logic               w_grant;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_idx;
  logic [DIN_W-1:0]   w_a;
  logic [DIN_W-1:0]   w_b;
  logic [2*DIN_W-1:0] w_a_x;
  logic [2*DIN_W-1:0] w_b_x;

  assign w_slot = !r_res_valid || bus.res_ready;

  // Scan from the pointer upward; index arithmetic wraps as NREQ is 2^ID_W.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_ptr + ID_W'(k);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant = ap_rst_n && w_slot && w_found;

  always_comb begin
    bus.req_ready = '0;
    if (w_grant) begin
      bus.req_ready[w_win] = 1'b1;
    end
  end

  assign w_a = bus.req_a[w_win*DIN_W +: DIN_W];
  assign w_b = bus.req_b[w_win*DIN_W +: DIN_W];

  // Sign-extended to full product width so the low bits match a signed multiply.
  assign w_a_x = {{DIN_W{w_a[DIN_W-1]}}, w_a};
  assign w_b_x = {{DIN_W{w_b[DIN_W-1]}}, w_b};

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_issue_cnt <= '0;
    end else if (w_grant) begin
      r_res_data  <= OUT_W'(w_a_x * w_b_x);
      r_res_id    <= w_win;
      r_res_valid <= 1'b1;
      r_ptr       <= w_win + ID_W'(1);
      r_issue_cnt <= r_issue_cnt + CNT_W'(1);
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign issue_cnt     = r_issue_cnt;

endmodule

// File: tb/tb_case_9_mul_rr_arbiter.sv
// Randomized bench for the shared-multiplier round-robin arbiter,
// checked against a cycle-level behavioural model kept in plain integers.
module tb_case_9_mul_rr_arbiter;
  localparam int N = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [15:0] issue_cnt;

  case_9_mul_rr_arbiter_if bus ();

  case_9_mul_rr_arbiter dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .issue_cnt(issue_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;

  int m_ptr = 0;
  int m_cnt = 0;
  int m_data = 0;
  int m_id = 0;
  bit m_valid = 1'b0;
  int opa[N];
  int opb[N];

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N] === 1'b1) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = pick(bus.req_valid);
    if (!ap_rst_n || (m_valid && !bus.res_ready) || w < 0) return '0;
    return N'(1) << w;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = int'($urandom_range(1023)) - 512;
      opb[i] = int'($urandom_range(1023)) - 512;
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input bit rr);
    bus.req_valid = v;
    bus.res_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*10 +: 10] = 10'(opa[i]);
      bus.req_b[i*10 +: 10] = 10'(opb[i]);
    end
  endtask

  task automatic tick();
    int w;
    bit slot;
    w = pick(bus.req_valid);
    slot = !m_valid || bus.res_ready;
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else if (slot && w >= 0) begin
      m_data  = (opa[w] * opb[w]) & 1023;
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % N;
      m_cnt   = (m_cnt + 1) % 65536;
    end else if (slot) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge ap_clk);
      rand_ops();
      drive(4'($urandom), 1'($urandom));
      #1;
      n_vec++;
      if (bus.req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
      end
      tick();
      n_vec++;
      if ({bus.res_valid, bus.res_data, bus.res_id, issue_cnt} !== 29'd0) begin
        n_err++;
        $display("FAIL reset_regs: got v=%b d=%h id=%0d cnt=%0d want all 0",
                 bus.res_valid, bus.res_data, bus.res_id, issue_cnt);
      end
    end
  endtask

  task automatic test_single();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    rand_ops();
    opa[2] = -3;
    opb[2] = 7;
    drive(4'b0100, 1'b1);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 10'h3EB ||
        bus.res_id !== 2'd2 || issue_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL single_result: got v=%b d=%h id=%0d cnt=%0d want 1 3eb 2 1",
               bus.res_valid, bus.res_data, bus.res_id, issue_cnt);
    end
  endtask

  task automatic test_truncation();
    int ta[3] = '{-512, 31, 511};
    int tb[3] = '{-512, 33, 2};
    logic [9:0] te[3] = '{10'h000, 10'h3FF, 10'h3FE};
    int r;
    for (int t = 0; t < 3; t++) begin
      @(negedge ap_clk);
      rand_ops();
      r = int'($urandom_range(N - 1));
      opa[r] = ta[t];
      opb[r] = tb[t];
      drive(N'(1) << r, 1'b1);
      tick();
      n_vec++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== te[t] ||
          bus.res_id !== 2'(r)) begin
        n_err++;
        $display("FAIL trunc_%0d: got v=%b d=%h id=%0d want 1 %h %0d",
                 t, bus.res_valid, bus.res_data, bus.res_id, te[t], r);
      end
    end
  endtask

  task automatic test_round_robin();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    drive('0, 1'b1);
    tick();
    for (int c = 0; c < 8; c++) begin
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      rand_ops();
      drive(4'hF, 1'b1);
      #1;
      n_vec++;
      if (!$onehot(bus.req_ready) || bus.req_ready !== exp_ready()) begin
        n_err++;
        $display("FAIL rr_ready_%0d: got %b want %b", c, bus.req_ready, exp_ready());
      end
      tick();
      n_vec++;
      if (bus.res_id !== 2'(c % 4) || bus.res_data !== 10'(m_data) ||
          bus.res_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rr_result_%0d: got id=%0d d=%h v=%b want id=%0d d=%h v=1",
                 c, bus.res_id, bus.res_data, bus.res_valid, c % 4, 10'(m_data));
      end
    end
    n_vec++;
    if (issue_cnt !== 16'd8) begin
      n_err++;
      $display("FAIL rr_count: got %0d want 8", issue_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] hd;
    logic [1:0] hid;
    hd  = bus.res_data;
    hid = bus.res_id;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      rand_ops();
      drive(4'hF, 1'b0);
      #1;
      n_vec++;
      if (bus.req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready_%0d: got %b want 0000", c, bus.req_ready);
      end
      tick();
      n_vec++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== hd || bus.res_id !== hid) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d want 1 %h %0d",
                 c, bus.res_valid, bus.res_data, bus.res_id, hd, hid);
      end
    end
    @(negedge ap_clk);
    rand_ops();
    drive(4'hF, 1'b1);
    tick();
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== hid + 2'd1 ||
        bus.res_data !== 10'(m_data)) begin
      n_err++;
      $display("FAIL bp_resume: got v=%b id=%0d d=%h want 1 %0d %h",
               bus.res_valid, bus.res_id, bus.res_data, hid + 2'd1, 10'(m_data));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge ap_clk);
    rand_ops();
    drive(4'hF, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL rmid_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.res_valid !== 1'b0 || issue_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rmid_clear: got v=%b cnt=%0d want 0 0", bus.res_valid, issue_cnt);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    rand_ops();
    drive(4'b1001, 1'b1);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_prio: got %b want 0001", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.res_id !== 2'd0 || bus.res_data !== 10'(m_data)) begin
      n_err++;
      $display("FAIL rmid_result: got id=%0d d=%h want 0 %h",
               bus.res_id, bus.res_data, 10'(m_data));
    end
  endtask

  task automatic test_wrap();
    @(negedge ap_clk);
    force dut.r_issue_cnt = 16'hFFFF;
    #1;
    release dut.r_issue_cnt;
    m_cnt = 65535;
    rand_ops();
    drive(4'b0010, 1'b1);
    tick();
    n_vec++;
    if (issue_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL cnt_wrap: got %h want 0000", issue_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge ap_clk);
      ap_rst_n = ($urandom_range(59) != 0);
      rand_ops();
      drive(4'($urandom), $urandom_range(3) != 0);
      #1;
      n_vec++;
      if (bus.req_ready !== exp_ready()) begin
        n_err++;
        $display("FAIL rnd_ready_%0d: got %b want %b", c, bus.req_ready, exp_ready());
      end
      tick();
      n_vec++;
      if (bus.res_valid !== m_valid || issue_cnt !== 16'(m_cnt) ||
          (m_valid && (bus.res_data !== 10'(m_data) || bus.res_id !== 2'(m_id)))) begin
        n_err++;
        $display("FAIL rnd_out_%0d: got v=%b d=%h id=%0d cnt=%0d want %b %h %0d %0d",
                 c, bus.res_valid, bus.res_data, bus.res_id, issue_cnt,
                 m_valid, 10'(m_data), m_id, m_cnt);
      end
    end
  endtask

  initial begin
    rand_ops();
    drive('0, 1'b0);
    test_reset();
    test_single();
    test_truncation();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/case_9_mul_rr_arbiter.md
# case_9_mul_rr_arbiter

Round-robin arbiter that shares one signed multiplier (DIN_W x DIN_W, low OUT_W bits kept) among NREQ requesters in the case_9 datapath. Each requester presents an operand pair on a valid/ready channel. The block grants at most one request per cycle, computes the truncated signed product, and returns it on a single registered result channel tagged with the requester index. An issue counter is exposed for performance monitoring.

## Interface
- NREQ, 4 — number of requesters; power of two, 2..8
- DIN_W, 10 — operand width, signed two's complement
- OUT_W, 10 — result width; low OUT_W bits of the full 2*DIN_W product
- ID_W, 2 — log2(NREQ)
- CNT_W, 16 — issue counter width
- ap_clk  in  1  single clock; all state updates on rising edge
- ap_rst_n  in  1  synchronous, active-low reset; sampled on ap_clk rising edge
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*DIN_W  operand A; requester i at bits [i*DIN_W +: DIN_W]
- req_b  in  NREQ*DIN_W  operand B, same packing
- res_valid  out  1  result register holds valid data
- res_ready  in  1  downstream accepts result
- res_data  out  OUT_W  truncated signed product
- res_id  out  ID_W  index of the requester that produced res_data
- issue_cnt  out  CNT_W  number of granted requests since reset; wraps

## Operation
- Free slot: `slot = !res_valid || res_ready`. Arbitration happens only when the slot is free.
- Round-robin pointer `ptr` (ID_W bits) holds the highest-priority index.
  - Winner is the first i in order ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ) with req_valid[i]=1.
- Grant:
  - req_ready[winner]=1 only when slot=1 and some req_valid is high; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr and res_valid/res_ready.
- On a handshake (req_valid[w] && req_ready[w]) the following register updates happen:
  - res_data <= low OUT_W bits of $signed(a_w)*$signed(b_w). The full product is 2*DIN_W bits, then truncated (modulo 2^OUT_W, no saturation).
  - res_id <= w; res_valid <= 1.
  - ptr <= w+1 (mod NREQ).
  - issue_cnt <= issue_cnt+1, wrapping at 2^CNT_W.
- If the slot is free and no request is valid:
  - res_valid <= 0 when res_ready consumed the held result.
  - ptr is unchanged.
- If res_valid=1 and res_ready=0:
  - res_data, res_id and res_valid hold stable.
  - All req_ready are 0.
  - ptr is unchanged.
- Simultaneous consume and new grant in the same cycle: the new result replaces the old one with no bubble, and res_valid stays 1.
- States are implicit in res_valid: EMPTY (0) and FULL (1).
  - EMPTY -> FULL on grant.
  - FULL -> FULL on stall, or on consume+grant.
  - FULL -> EMPTY on consume with no grant.
- Reset (ap_rst_n=0 at a clock edge) clears everything, including mid-transaction:
  - res_valid=0, res_data=0, res_id=0, ptr=0, issue_cnt=0.
  - req_ready=0 during the reset cycle.
  - Any held result is discarded.

## Timing
- Latency: a request accepted at edge k has res_valid=1 with its result after edge k.
- Throughput: one result per cycle when res_ready=1 continuously.
- Multiplier path: combinational from the granted operand mux to the res_data register; no internal multiplier pipeline.
- Operands need to be valid only in the handshake cycle.
- req_ready never asserts without a corresponding req_valid.
- No output is combinationally dependent on req_a or req_b.
- First cycle after reset deassertion: request acceptance is allowed, with ptr=0 giving priority to requester 0.

## Test plan
- Reset values: hold ap_rst_n=0 for 2 cycles with random inputs.
  - Required: req_ready=0, res_valid=0, res_data=0, res_id=0, issue_cnt=0.
- Single request: requester 2, a=-3, b=7, res_ready=1.
  - Required: one cycle later res_valid=1, res_data=10'h3EB (-21), res_id=2, issue_cnt=1.
- Truncation, one request per vector:
  - a=-512, b=-512 -> res_data=10'h000.
  - a=31, b=33 -> 10'h3FF.
  - a=511, b=2 -> 10'h3FE.
- Round robin: all four req_valid held high, res_ready=1, 8 cycles.
  - Required: res_id sequence 0,1,2,3,0,1,2,3; req_ready one-hot each cycle; issue_cnt=8.
- Backpressure: result pending, res_ready=0 for 5 cycles with all requests valid.
  - Required: res_data/res_id stable; req_ready=0.
  - On res_ready=1, the next result follows with no bubble, next id = previous id+1.
- Reset mid-operation: assert ap_rst_n=0 while res_valid=1 and res_ready=0.
  - Required: res_valid=0 next cycle; after release, requester 0 wins when requesters 0 and 3 are both valid.
  - issue_cnt wrap: force 16'hFFFF, then one grant -> 16'h0000.
